// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the clock-throttle controller.
// - throttle_state_e : FSM state encoding (0 idle, 1 gate, 2 ramp; 3 unused)
// - RAMP_P0          : ramp period of the first (slowest) level, in cycles
// - ramp_last_phase  : last phase index of a ramp level (period-1)
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGate = 2'd1,
    StRamp = 2'd2
  } throttle_state_e;

  localparam int unsigned RAMP_P0 = 8;

  // Level L runs with period RAMP_P0 >> L; the enable pulse sits on the last phase.
  function automatic logic [2:0] ramp_last_phase(input logic [1:0] lvl);
    return 3'((RAMP_P0 >> lvl) - 1);
  endfunction

endpackage

// File: rtl/cv32e40p_throttle_ramp_gen.sv
// Duty-cycled restore ramp: three levels with periods 8, 4, 2, each repeated
// rper_i times.
// Ports:
//   clk_ungated_i, rst_i : free-running clock, synchronous active-high reset
//   clr_i                : hold all counters at zero (not advancing in RAMP)
//   rper_i               : periods per level (shadowed by the controller)
//   pulse_nxt_o          : enable value for the phase that becomes current next cycle
//   done_o               : current cycle is the final phase of the final level
module cv32e40p_throttle_ramp_gen
  import cv32e40p_pkg::*;
#(
  parameter int unsigned RAMP_W = 4
) (
  input  logic              clk_ungated_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic [RAMP_W-1:0] rper_i,
  output logic              pulse_nxt_o,
  output logic              done_o
);

  logic [2:0]        phase_q, phase_d;
  logic [RAMP_W-1:0] per_q, per_d;
  logic [1:0]        lvl_q, lvl_d;
  logic              last_phase;
  logic              last_per;

  assign last_phase = (phase_q == ramp_last_phase(lvl_q));
  // Extra bit so the compare cannot wrap at the top of the rper range.
  assign last_per   = (({1'b0, per_q} + (RAMP_W + 1)'(1)) == {1'b0, rper_i});
  assign done_o     = last_phase && last_per && (lvl_q == 2'd2);

  always_comb begin
    phase_d = phase_q;
    per_d   = per_q;
    lvl_d   = lvl_q;
    if (clr_i) begin
      phase_d = '0;
      per_d   = '0;
      lvl_d   = '0;
    end else if (last_phase) begin
      phase_d = '0;
      if (last_per) begin
        per_d = '0;
        lvl_d = lvl_q + 2'd1;
      end else begin
        per_d = per_q + RAMP_W'(1);
      end
    end else begin
      phase_d = phase_q + 3'd1;
    end
  end

  assign pulse_nxt_o = (phase_d == ramp_last_phase(lvl_d));

  always_ff @(posedge clk_ungated_i) begin
    if (rst_i) begin
      phase_q <= '0;
      per_q   <= '0;
      lvl_q   <= '0;
    end else begin
      phase_q <= phase_d;
      per_q   <= per_d;
      lvl_q   <= lvl_d;
    end
  end

endmodule

// File: rtl/cv32e40p_clk_throttle_ctrl.sv
// Droop-aware clock-enable sequencer for the core clock gate. A droop alarm
// hard-gates the core clock for a programmable hold, then a duty-cycled ramp
// (1/8, 1/4, 1/2) restores it before returning to full enable.
// Ports:
//   clk_ungated_i, rst_i : free-running clock, synchronous active-high reset
//   cfg_en_i             : throttle enable (0 forces idle)
//   cfg_hold_i           : gate hold length in cycles (0 behaves as 1)
//   cfg_ramp_periods_i   : periods per ramp level (0 skips the ramp)
//   droop_alarm_i        : level-sensitive droop alarm
//   evt_clr_i            : clear the event counter
//   clk_out_riscv_en_o   : registered clock enable to the sleep unit
//   throttle_active_o    : registered, high while not idle
//   state_o              : current FSM state
//   evt_cnt_o            : saturating count of idle-to-gate entries
module cv32e40p_clk_throttle_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned HOLD_W = 8,
  parameter int unsigned RAMP_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_ungated_i,
  input  logic              rst_i,
  input  logic              cfg_en_i,
  input  logic [HOLD_W-1:0] cfg_hold_i,
  input  logic [RAMP_W-1:0] cfg_ramp_periods_i,
  input  logic              droop_alarm_i,
  input  logic              evt_clr_i,
  output logic              clk_out_riscv_en_o,
  output logic              throttle_active_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  evt_cnt_o
);

  throttle_state_e   state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [RAMP_W-1:0] rper_q, rper_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
  logic              en_q, en_d;
  logic              active_q, active_d;
  logic [HOLD_W-1:0] hold_cfg;
  logic              evt_inc;
  logic              ramp_clr;
  logic              ramp_pulse_nxt;
  logic              ramp_done;

  assign hold_cfg = (cfg_hold_i == '0) ? HOLD_W'(1) : cfg_hold_i;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    rper_d     = rper_q;
    hold_cnt_d = hold_cnt_q;
    evt_inc    = 1'b0;
    if (!cfg_en_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (droop_alarm_i) begin
            state_d    = StGate;
            hold_d     = hold_cfg;
            rper_d     = cfg_ramp_periods_i;
            hold_cnt_d = hold_cfg;
            evt_inc    = 1'b1;
          end
        end
        StGate: begin
          if (droop_alarm_i) begin
            hold_cnt_d = hold_q;
          end else if (hold_cnt_q <= HOLD_W'(1)) begin
            state_d = (rper_q != '0) ? StRamp : StIdle;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          end
        end
        StRamp: begin
          if (droop_alarm_i) begin
            state_d    = StGate;
            hold_cnt_d = hold_q;
          end else if (ramp_done) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Clear wins over a coincident increment.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (evt_clr_i) begin
      evt_cnt_d = '0;
    end else if (evt_inc && !(&evt_cnt_q)) begin
      evt_cnt_d = evt_cnt_q + CNT_W'(1);
    end
  end

  // Ramp counters only advance while staying in RAMP; any other path restarts them.
  assign ramp_clr = !((state_q == StRamp) && (state_d == StRamp));

  // Outputs are registered from the next state so they line up with state_q.
  assign en_d     = (state_d == StGate) ? 1'b0 :
                    (state_d == StRamp) ? ramp_pulse_nxt : 1'b1;
  assign active_d = (state_d != StIdle);

  cv32e40p_throttle_ramp_gen #(
    .RAMP_W (RAMP_W)
  ) u_ramp_gen (
    .clk_ungated_i (clk_ungated_i),
    .rst_i         (rst_i),
    .clr_i         (ramp_clr),
    .rper_i        (rper_q),
    .pulse_nxt_o   (ramp_pulse_nxt),
    .done_o        (ramp_done)
  );

  always_ff @(posedge clk_ungated_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      rper_q     <= '0;
      hold_cnt_q <= '0;
      evt_cnt_q  <= '0;
      en_q       <= 1'b1;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rper_q     <= rper_d;
      hold_cnt_q <= hold_cnt_d;
      evt_cnt_q  <= evt_cnt_d;
      en_q       <= en_d;
      active_q   <= active_d;
    end
  end

  assign clk_out_riscv_en_o = en_q;
  assign throttle_active_o  = active_q;
  assign state_o            = state_q;
  assign evt_cnt_o          = evt_cnt_q;

endmodule

// File: tb/tb_cv32e40p_clk_throttle_ctrl.sv
// Bench for the clock-throttle controller: directed vector table, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_cv32e40p_clk_throttle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b0;
  logic [7:0]  cfg_hold = 8'd0;
  logic [3:0]  cfg_ramp = 4'd0;
  logic        alarm = 1'b0;
  logic        clr = 1'b0;
  logic        en_o, act_o, en_s, act_s;
  logic [1:0]  st_o, st_s;
  logic [15:0] cnt_o;
  logic [3:0]  cnt_s;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cv32e40p_clk_throttle_ctrl dut (
    .clk_ungated_i      (clk),
    .rst_i              (rst),
    .cfg_en_i           (cfg_en),
    .cfg_hold_i         (cfg_hold),
    .cfg_ramp_periods_i (cfg_ramp),
    .droop_alarm_i      (alarm),
    .evt_clr_i          (clr),
    .clk_out_riscv_en_o (en_o),
    .throttle_active_o  (act_o),
    .state_o            (st_o),
    .evt_cnt_o          (cnt_o)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  cv32e40p_clk_throttle_ctrl #(.CNT_W(4)) dut_sat (
    .clk_ungated_i      (clk),
    .rst_i              (rst),
    .cfg_en_i           (cfg_en),
    .cfg_hold_i         (cfg_hold),
    .cfg_ramp_periods_i (cfg_ramp),
    .droop_alarm_i      (alarm),
    .evt_clr_i          (clr),
    .clk_out_riscv_en_o (en_s),
    .throttle_active_o  (act_s),
    .state_o            (st_s),
    .evt_cnt_o          (cnt_s)
  );

  // Reference model: mode 0 idle, 1 gate, 2 ramp; k = cycles since ramp start.
  int m_mode = 0, m_rem = 0, m_k = 0, m_hold = 0, m_rper = 0, m_cnt = 0, m_cnt_s = 0;

  task automatic model_step();
    int inc = 0;
    if (rst) begin
      m_mode = 0; m_rem = 0; m_k = 0; m_hold = 0; m_rper = 0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      if (!cfg_en) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (alarm) begin
          m_mode = 1;
          m_hold = (int'(cfg_hold) == 0) ? 1 : int'(cfg_hold);
          m_rper = int'(cfg_ramp);
          m_rem  = m_hold;
          inc    = 1;
        end
      end else if (m_mode == 1) begin
        if (alarm) m_rem = m_hold;
        else if (m_rem == 1) begin
          if (m_rper > 0) begin m_mode = 2; m_k = 0; end
          else m_mode = 0;
        end else m_rem = m_rem - 1;
      end else begin
        if (alarm) begin m_mode = 1; m_rem = m_hold; end
        else if (m_k == 14 * m_rper - 1) m_mode = 0;
        else m_k = m_k + 1;
      end
      if (clr) begin
        m_cnt = 0; m_cnt_s = 0;
      end else if (inc == 1) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt_s < 15) m_cnt_s = m_cnt_s + 1;
      end
    end
  endtask

  function automatic int model_en();
    int r;
    r = m_rper;
    if (m_mode == 0) return 1;
    if (m_mode == 1) return 0;
    if (m_k < 8 * r) return (m_k % 8 == 7) ? 1 : 0;
    if (m_k < 12 * r) return ((m_k - 8 * r) % 4 == 3) ? 1 : 0;
    return ((m_k - 12 * r) % 2 == 1) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // One clock: model consumes the same inputs the DUT sampled, then compare.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_en", int'(en_o), model_en());
    check("model_active", int'(act_o), (m_mode != 0) ? 1 : 0);
    check("model_state", int'(st_o), m_mode);
    check("model_cnt", int'(cnt_o), m_cnt);
    check("model_cnt_sat", int'(cnt_s), m_cnt_s);
  endtask

  task automatic do_reset();
    rst = 1'b1; alarm = 1'b0; clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic rst; logic en; int hold; int ramp; logic alarm; logic clr;
    logic x_en; logic x_act; int x_st; int x_cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, int h, int rp, logic a, logic c,
                              logic xe, logic xa, int xs, int xc);
    vec_t v;
    v.rst = r; v.en = e; v.hold = h; v.ramp = rp; v.alarm = a; v.clr = c;
    v.x_en = xe; v.x_act = xa; v.x_st = xs; v.x_cnt = xc;
    return v;
  endfunction

  vec_t tbl[10];
  logic [15:0] pat;

  initial begin
    // Single-cycle alarm, hold=5, no ramp: en low for exactly five cycles.
    tbl[0] = mk(1, 1, 5, 0, 0, 0, 1, 0, 0, 0);
    tbl[1] = mk(0, 1, 5, 0, 0, 0, 1, 0, 0, 0);
    tbl[2] = mk(0, 1, 5, 0, 1, 0, 0, 1, 1, 1);
    tbl[3] = mk(0, 1, 5, 0, 0, 0, 0, 1, 1, 1);
    tbl[4] = mk(0, 1, 5, 0, 0, 0, 0, 1, 1, 1);
    tbl[5] = mk(0, 1, 5, 0, 0, 0, 0, 1, 1, 1);
    tbl[6] = mk(0, 1, 5, 0, 0, 0, 0, 1, 1, 1);
    tbl[7] = mk(0, 1, 5, 0, 0, 0, 1, 0, 0, 1);
    tbl[8] = mk(0, 1, 5, 0, 0, 0, 1, 0, 0, 1);
    tbl[9] = mk(0, 1, 5, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; cfg_en = tbl[i].en; cfg_hold = 8'(tbl[i].hold);
      cfg_ramp = 4'(tbl[i].ramp); alarm = tbl[i].alarm; clr = tbl[i].clr;
      tick();
      check("tbl_en", int'(en_o), int'(tbl[i].x_en));
      check("tbl_active", int'(act_o), int'(tbl[i].x_act));
      check("tbl_state", int'(st_o), tbl[i].x_st);
      check("tbl_cnt", int'(cnt_o), tbl[i].x_cnt);
    end
    clr = 1'b0;

    // Full ramp: hold=2, ramp=1.
    do_reset();
    cfg_en = 1'b1; cfg_hold = 8'd2; cfg_ramp = 4'd1; alarm = 1'b1;
    tick();
    check("ramp_gate_state", int'(st_o), 1);
    alarm = 1'b0;
    tick();
    check("ramp_gate_en", int'(en_o), 0);
    pat = 16'b0000000100010111;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("ramp_pattern_en", int'(en_o), int'(pat[15-i]));
    end
    check("ramp_exit_state", int'(st_o), 0);

    // Alarm in GATE extends the hold; alarm in level 1 regates with full hold.
    do_reset();
    cfg_hold = 8'd3; cfg_ramp = 4'd1; alarm = 1'b1;
    tick();
    alarm = 1'b0; tick();
    alarm = 1'b1; tick();
    alarm = 1'b0; tick(); tick();
    check("regate_still_gate", int'(st_o), 1);
    tick();
    check("regate_ramp_entry", int'(st_o), 2);
    for (int i = 0; i < 8; i++) tick();
    alarm = 1'b1; tick();
    check("ramp_alarm_state", int'(st_o), 1);
    check("ramp_alarm_cnt", int'(cnt_o), 1);
    alarm = 1'b0; tick(); tick();
    check("ramp_alarm_hold", int'(st_o), 1);
    tick();
    check("ramp_restart_state", int'(st_o), 2);
    for (int i = 0; i < 6; i++) tick();
    check("ramp_restart_p8_low", int'(en_o), 0);
    tick();
    check("ramp_restart_p8_high", int'(en_o), 1);
    check("ramp_restart_cnt", int'(cnt_o), 1);

    // hold=0 behaves as 1; hold change while gated is ignored.
    do_reset();
    cfg_hold = 8'd0; cfg_ramp = 4'd0; alarm = 1'b1;
    tick();
    check("hold0_en_low", int'(en_o), 0);
    alarm = 1'b0; tick();
    check("hold0_en_back", int'(en_o), 1);
    cfg_hold = 8'd3; alarm = 1'b1; tick();
    alarm = 1'b0; cfg_hold = 8'd20; tick(); tick();
    check("shadow_hold_gate", int'(st_o), 1);
    tick();
    check("shadow_hold_done", int'(st_o), 0);

    // Disable mid-ramp; clear colliding with an increment.
    do_reset();
    cfg_hold = 8'd1; cfg_ramp = 4'd2; alarm = 1'b1; tick();
    alarm = 1'b0; tick();
    for (int i = 0; i < 5; i++) tick();
    check("dis_in_ramp", int'(st_o), 2);
    cfg_en = 1'b0; tick();
    check("dis_en", int'(en_o), 1);
    check("dis_state", int'(st_o), 0);
    cfg_en = 1'b1; clr = 1'b1; alarm = 1'b1; tick();
    check("clr_win_cnt", int'(cnt_o), 0);
    check("clr_win_state", int'(st_o), 1);
    clr = 1'b0; alarm = 1'b0; tick();

    // Saturation on the 4-bit instance.
    do_reset();
    cfg_hold = 8'd1; cfg_ramp = 4'd0;
    for (int i = 0; i < 20; i++) begin
      alarm = 1'b1; tick();
      alarm = 1'b0; tick();
    end
    check("sat_cnt_narrow", int'(cnt_s), 15);
    check("sat_cnt_wide", int'(cnt_o), 20);

    // Synchronous reset while gated.
    do_reset();
    cfg_hold = 8'd10; alarm = 1'b1; tick();
    alarm = 1'b0; tick();
    rst = 1'b1; tick();
    check("rst_gate_en", int'(en_o), 1);
    check("rst_gate_state", int'(st_o), 0);
    check("rst_gate_cnt", int'(cnt_o), 0);
    rst = 1'b0;

    // Randomized traffic, alternating busy and quiet alarm rates.
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 500; i++) begin
        rst      = ($urandom_range(0, 299) == 0);
        cfg_en   = ($urandom_range(0, 59) != 0);
        cfg_hold = 8'($urandom_range(0, 6));
        cfg_ramp = 4'($urandom_range(0, 3));
        alarm    = (blk % 2 == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 79) == 0);
        clr      = ($urandom_range(0, 149) == 0);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cv32e40p_clk_throttle_ctrl.md
# cv32e40p_clk_throttle_ctrl

Droop-aware clock-enable sequencer for the CV32E40P core clock gate. It drives the `clk_out_riscv_en` input of the core sleep unit. On a supply-droop alarm it hard-gates the core clock for a programmable hold time, then restores it through a duty-cycled ramp (1/8 → 1/4 → 1/2 → full) to limit di/dt. It runs on the free-running clock, in parallel with the sleep unit, and counts throttle events for software.

## Interface
Parameters:
- `HOLD_W`, 8: width of hold-cycle config.
- `RAMP_W`, 4: width of ramp-periods config.
- `CNT_W`, 16: width of event counter.

Ports:
- `clk_ungated_i`, in, 1: free-running clock; never gated by this block.
- `rst_i`, in, 1: one clock; reset is synchronous and active-high.
- `cfg_en_i`, in, 1: throttle enable; 0 forces IDLE.
- `cfg_hold_i`, in, `HOLD_W`: gate hold length in cycles; 0 is treated as 1.
- `cfg_ramp_periods_i`, in, `RAMP_W`: periods per ramp level; 0 skips the ramp.
- `droop_alarm_i`, in, 1: synchronous droop alarm, level-sensitive.
- `evt_clr_i`, in, 1: clears the event counter.
- `clk_out_riscv_en_o`, out, 1: registered clock enable to the sleep unit.
- `throttle_active_o`, out, 1: 1 whenever state ≠ IDLE.
- `state_o`, out, 2: current FSM state, for debug.
- `evt_cnt_o`, out, `CNT_W`: saturating count of IDLE→GATE entries.

## Operation
- **Reset values:** state=IDLE, `clk_out_riscv_en_o`=1, `throttle_active_o`=0, `evt_cnt_o`=0, all counters 0.
- **States:** IDLE(0), GATE(1), RAMP(2). Encoding 3 is unused and recovers to IDLE.
- **IDLE:**
  - en=1.
  - `droop_alarm_i`&&`cfg_en_i` → GATE.
  - On entry to GATE: shadow `cfg_hold_i` (0→1) into `hold_q`, shadow `cfg_ramp_periods_i` into `rper_q`, load hold counter=`hold_q`, increment `evt_cnt` (saturate at all-ones).
- **GATE:**
  - en=0. Hold counter decrements each cycle.
  - Alarm still high → reload counter with `hold_q`; no event increment.
  - Counter reaches 1 with no alarm → RAMP if `rper_q`≠0, else IDLE.
- **RAMP:**
  - Level L ∈ {0,1,2}, period P = 8>>L (8, 4, 2). Phase counter runs 0..P-1; en=1 only when phase==P-1.
  - Period counter increments at phase P-1. After `rper_q` periods, L advances and phase resets to 0.
  - After level 2 completes → IDLE.
  - Alarm in RAMP → GATE with hold counter reloaded, L and phase reset; no event increment.
- **`cfg_en_i`=0** in any state → IDLE next cycle, en=1 next cycle. A simultaneous alarm is ignored.
- **Config changes** mid-throttle have no effect until the next IDLE→GATE entry, because shadows are loaded only on that entry.
- **`evt_clr_i`:** clears the counter next cycle. If it coincides with an increment, the clear wins (result 0).

## Timing
- **Alarm latency:** alarm sampled high at edge t in IDLE → en=0 from t+1.
- **Hold:** en low for exactly `hold_q` cycles after the alarm deasserts. A single-cycle alarm with hold=H gives en=0 for cycles t+1..t+H.
- **Ramp pattern:** en high on the last cycle of each period. Total ramp length = `rper_q`·(8+4+2) cycles.
- **Ramp exit:** en=1 continuously from the first IDLE cycle.
- **Output registering:** `clk_out_riscv_en_o` and `throttle_active_o` are registered outputs; no combinational path from any input.
- **Reset mid-throttle:** outputs take their reset values at the next edge.

## Structure
- **Shared package:** the `throttle_state_e` enum (IDLE/GATE/RAMP) and the ramp base period constant `RAMP_P0=8` go into `cv32e40p_pkg`.
- **Sub-module:** one natural sub-module, `cv32e40p_throttle_ramp_gen`, holding the phase, period and level counters. Its I/O: start/clear, `rper_q`, en pulse, done.
- **Top level:** FSM, hold counter, shadows and event counter.
- **Expected size:** about 200 lines of RTL.

## Test plan
- **Single-cycle alarm, no ramp:** reset, then `cfg_en_i`=1, hold=5, ramp=0, one-cycle alarm at t=10 → en=0 for cycles 11–15, en=1 from 16, `evt_cnt_o`=1.
- **Full ramp:** hold=2, ramp=1, single alarm → en pattern after the hold: 0000000100010111…, i.e. high once per 8, then per 4, then per 2. Ramp lasts 14 cycles, then IDLE with en=1.
- **Alarm during GATE and RAMP:** a second alarm in GATE extends the hold (reload). An alarm in the second ramp level → GATE, full hold reloaded, level restarts at P=8, `evt_cnt_o` stays 1.
- **Hold=0 and config change mid-throttle:** hold=0 → en low for exactly 1 cycle. Changing `cfg_hold_i` from 3 to 20 while in GATE does not alter the current hold.
- **Disable, clear/increment collision, saturation:** `cfg_en_i` dropped mid-RAMP → en=1 and state=IDLE next cycle. `evt_clr_i` coincident with a new alarm → `evt_cnt_o`=0. Counter preset near all-ones saturates at 0xFFFF.
- **Synchronous reset during GATE:** next cycle en=1, state=0, `evt_cnt_o`=0.
